// File: rtl/shift_tx_scheduler.sv
// Two-requester round-robin front end to a single LSB-first serial shift-out path.
// Each frame is WIDTH bits followed by GAP idle cycles before the next grant.
module shift_tx_scheduler #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             grant_id,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
    localparam logic [3:0]      GapLast = 4'((GAP == 0) ? 0 : GAP - 1);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    state_e           state;
    logic [WIDTH-1:0] shreg;
    logic [CntW-1:0]  bit_cnt;
    logic [3:0]       gap_cnt;
    logic             ptr;
    logic             gnt0;
    logic             gnt1;
    logic             last_bit;

    // ptr == 0 favours requester 0 when both are valid
    always_comb begin
        gnt0 = req0_valid && (!req1_valid || !ptr);
        gnt1 = req1_valid && (!req0_valid || ptr);
    end

    // Readys are held low during reset even though the FSM sits in IDLE
    assign req0_ready = rst_n && (state == StIdle) && gnt0;
    assign req1_ready = rst_n && (state == StIdle) && gnt1;

    assign last_bit  = (state == StShift) && (bit_cnt == LastBit);
    assign ser_valid = (state == StShift);
    assign busy      = (state != StIdle);
    assign done      = last_bit;
    // shreg drains to all-zero by the end of a frame, so ser_out idles low
    assign ser_out   = shreg[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            shreg    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            ptr      <= 1'b0;
            grant_id <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (gnt0 || gnt1) begin
                        shreg    <= gnt1 ? req1_data : req0_data;
                        grant_id <= gnt1;
                        ptr      <= !gnt1;
                        bit_cnt  <= '0;
                        state    <= StShift;
                    end
                end
                StShift: begin
                    shreg <= shreg >> 1;
                    if (last_bit) begin
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                        state   <= (GAP == 0) ? StIdle : StGap;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                StGap: begin
                    if (gap_cnt == GapLast) begin
                        state <= StIdle;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_tx_scheduler.sv
// Directed bench for shift_tx_scheduler: one instance with GAP=1, one with GAP=0.
// Expected serial bits are queued at each handshake and popped as frame bits appear.
module tb_shift_tx_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       v0, v1, r0, r1, so, sv, gid, bsy, dn;
    logic [7:0] d0, d1;
    logic       zv0, zv1, zr0, zr1, zso, zsv, zgid, zbsy, zdn;
    logic [7:0] zd0, zd1;

    shift_tx_scheduler #(.WIDTH(8), .GAP(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
        .ser_out(so), .ser_valid(sv), .grant_id(gid), .busy(bsy), .done(dn)
    );

    shift_tx_scheduler #(.WIDTH(8), .GAP(0)) dut_nogap (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(zv0), .req0_data(zd0), .req0_ready(zr0),
        .req1_valid(zv1), .req1_data(zd1), .req1_ready(zr1),
        .ser_out(zso), .ser_valid(zsv), .grant_id(zgid), .busy(zbsy), .done(zdn)
    );

    int   checks = 0;
    int   errors = 0;
    int   nvalid = 0;
    int   ndone  = 0;
    logic exp_q[$];

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] d);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    endtask

    // Entered at the sample point of the first bit cycle; leaves one cycle after the last bit
    task automatic shift_check(input bit z, input logic egid, input string tag);
        for (int k = 1; k <= 8; k++) begin
            logic s_v, s_o, s_d, s_g, s_b;
            s_v = z ? zsv : sv;
            s_o = z ? zso : so;
            s_d = z ? zdn : dn;
            s_g = z ? zgid : gid;
            s_b = z ? zbsy : bsy;
            if (z && s_v) nvalid++;
            if (z && s_d) ndone++;
            chk({tag, ".valid"}, s_v, 1'b1);
            chk({tag, ".done"}, s_d, k == 8);
            chk({tag, ".busy"}, s_b, 1'b1);
            chk({tag, ".gid"}, s_g, egid);
            if (s_v) begin
                chk({tag, ".sb_nonempty"}, exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk({tag, ".bit"}, s_o, exp_q.pop_front());
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        v0 = 1'b1; v1 = 1'b1; d0 = 8'h01; d1 = 8'h80;
        zv0 = 1'b0; zv1 = 1'b0; zd0 = 8'h00; zd1 = 8'h00;
        #2;
        // Reset with both valids high
        chk("rst.ser_out", so, 1'b0);
        chk("rst.ser_valid", sv, 1'b0);
        chk("rst.busy", bsy, 1'b0);
        chk("rst.done", dn, 1'b0);
        chk("rst.grant_id", gid, 1'b0);
        chk("rst.ready0", r0, 1'b0);
        chk("rst.ready1", r1, 1'b0);
        chk("rst.z_valid", zsv, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel.ready0", r0, 1'b1);
        chk("rel.ready1", r1, 1'b0);

        // Contention: grants alternate 0,1,0
        push_frame(8'h01);
        tick();
        shift_check(1'b0, 1'b0, "c0");
        chk("c0.gap_valid", sv, 1'b0);
        chk("c0.gap_busy", bsy, 1'b1);
        chk("c0.gap_ready0", r0, 1'b0);
        chk("c0.gap_ready1", r1, 1'b0);
        tick();
        chk("c1.idle_busy", bsy, 1'b0);
        chk("c1.ready1", r1, 1'b1);
        chk("c1.ready0", r0, 1'b0);
        push_frame(8'h80);
        tick();
        shift_check(1'b0, 1'b1, "c1");
        chk("c1.gap_valid", sv, 1'b0);
        tick();
        chk("c2.ready0", r0, 1'b1);
        chk("c2.ready1", r1, 1'b0);
        chk("c2.gid_last", gid, 1'b1);
        push_frame(8'h01);
        tick();
        shift_check(1'b0, 1'b0, "c2");
        v0 = 1'b0; v1 = 1'b0;
        tick();
        chk("c2.idle_busy", bsy, 1'b0);

        // Single frame 8'hA5 from requester 0
        v0 = 1'b1; d0 = 8'hA5;
        #1;
        chk("s.ready0", r0, 1'b1);
        push_frame(8'hA5);
        tick();
        shift_check(1'b0, 1'b0, "s");
        chk("s.t9_busy", bsy, 1'b1);
        chk("s.t9_valid", sv, 1'b0);
        chk("s.t9_ready0", r0, 1'b0);
        tick();
        chk("s.t10_busy", bsy, 1'b0);
        chk("s.t10_ready0", r0, 1'b1);
        v0 = 1'b0;

        // Valid withdrawn before the grant edge; pointer should still favour requester 1
        v1 = 1'b1; d1 = 8'hFF;
        #1;
        chk("w.ready1", r1, 1'b1);
        v1 = 1'b0;
        tick();
        chk("w.no_valid", sv, 1'b0);
        chk("w.no_busy", bsy, 1'b0);
        v0 = 1'b1; v1 = 1'b1;
        #1;
        chk("w.ptr_ready1", r1, 1'b1);
        chk("w.ptr_ready0", r0, 1'b0);
        v0 = 1'b0; v1 = 1'b0;

        // Reset after three bits of a frame
        v0 = 1'b1; d0 = 8'h3C;
        #1;
        push_frame(8'h3C);
        tick();
        v0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("m.valid", sv, 1'b1);
            chk("m.bit", so, exp_q.pop_front());
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("m.rst_valid", sv, 1'b0);
        chk("m.rst_done", dn, 1'b0);
        chk("m.rst_busy", bsy, 1'b0);
        chk("m.rst_out", so, 1'b0);
        exp_q.delete();
        tick();
        chk("m.rst_done2", dn, 1'b0);
        rst_n = 1'b1;
        v1 = 1'b1; d1 = 8'hC3;
        #1;
        chk("m.lone_ready1", r1, 1'b1);
        push_frame(8'hC3);
        tick();
        v1 = 1'b0;
        shift_check(1'b0, 1'b1, "m");

        // GAP=0 back-to-back on requester 1
        zv1 = 1'b1; zd1 = 8'h96;
        #1;
        chk("z.ready1", zr1, 1'b1);
        push_frame(8'h96);
        tick();
        zd1 = 8'h5A;
        nvalid = 0; ndone = 0;
        shift_check(1'b1, 1'b1, "z0");
        chk("z.mid_busy", zbsy, 1'b0);
        chk("z.mid_ready1", zr1, 1'b1);
        push_frame(8'h5A);
        tick();
        shift_check(1'b1, 1'b1, "z1");
        zv1 = 1'b0;
        chk("z.end_valid", zsv, 1'b0);
        chk("z.nvalid16", nvalid == 16, 1'b1);
        chk("z.ndone2", ndone == 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
